conv_pool: RTL and testbench

- Post-processing stage directly downstream of the 3x3 convolution engine; consumes its output_data/fin result stream.
- Per result: ReLU, requantisation to unsigned 8 bit by arithmetic right shift with saturation, then 2x2 stride-2 max pooling over a MAP_W x MAP_H feature map in raster order.
- Emits one pooled byte per 2x2 window and a frame-done pulse; feeds the next layer's input buffer.

---
 rtl/conv_pool_pkg.sv | 27 ++
 rtl/conv_pool_if.sv | 36 +++
 rtl/conv_pool_requant.sv | 37 +++
 rtl/conv_pool.sv | 161 ++++++++++++++++
 tb/tb_conv_pool.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pool_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv_pkg (package)
//  Purpose  : Shared types and constants for the conv_pool post-processing
//             stage (ReLU + requantisation + 2x2 max pooling).
//  Revision : 1.0  initial release
// ============================================================================
package conv_pkg;

    typedef logic signed [15:0] conv_res_t;
    typedef logic        [7:0]  pix_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } pool_state_t;

    localparam pix_t PIX_MAX = 8'hFF;

    // Larger of two unsigned pixels; on a tie either operand is the answer.
    function automatic pix_t pix_max(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_pool_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv_pool_if
//  Purpose  : Result stream from the conv engine into conv_pool and the
//             pooled byte stream out of it.
//             CONV_POOL_SATCNT_EN adds the sat_count observation signal.
//  Revision : 1.0  initial release
// ============================================================================
interface conv_pool_if;
    import conv_pkg::*;

    logic      clr;
    conv_res_t conv_data;
    logic      conv_fin;
    pix_t      pool_data;
    logic      pool_valid;
    logic      frame_done;
    logic      busy;
`ifdef CONV_POOL_SATCNT_EN
    logic [15:0] sat_count;
`endif

`ifdef CONV_POOL_SATCNT_EN
    modport slave  (input  clr, conv_data, conv_fin,
                    output pool_data, pool_valid, frame_done, busy, sat_count);
    modport master (output clr, conv_data, conv_fin,
                    input  pool_data, pool_valid, frame_done, busy, sat_count);
`else
    modport slave  (input  clr, conv_data, conv_fin,
                    output pool_data, pool_valid, frame_done, busy);
    modport master (output clr, conv_data, conv_fin,
                    input  pool_data, pool_valid, frame_done, busy);
`endif

endinterface
`default_nettype wire

// File: rtl/conv_pool_requant.sv
`default_nettype none
// ============================================================================
//  Module   : requant_relu
//  Purpose  : Combinational ReLU + arithmetic right shift + saturation of a
//             signed conv result to an unsigned 8-bit pixel. sat_o flags a
//             non-negative input whose shifted value exceeded the pixel range.
//  Revision : 1.0  initial release
// ============================================================================
module requant_relu
    import conv_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  conv_res_t data_i,
    output pix_t      pix_o,
    output logic      sat_o
);

    conv_res_t shifted;

    // Negative results clamp to zero; large positives clamp to PIX_MAX.
    always_comb begin
        shifted = data_i >>> SHIFT;
        pix_o   = '0;
        sat_o   = 1'b0;
        if (data_i[15]) begin
            pix_o = '0;
        end else if (shifted > $signed({8'd0, PIX_MAX})) begin
            pix_o = PIX_MAX;
            sat_o = 1'b1;
        end else begin
            pix_o = shifted[7:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_pool.sv
`default_nettype none
// ============================================================================
//  Module   : conv_pool
//  Purpose  : Post-processing of the 3x3 conv result stream: ReLU,
//             requantisation to 8 bit, then 2x2 stride-2 max pooling over a
//             MAP_W x MAP_H raster-ordered feature map. One pooled byte per
//             window, frame_done on the last window of a frame.
//  Options  : CONV_POOL_SATCNT_EN - per-frame count of saturated samples.
//  Revision : 1.0  initial release
// ============================================================================
module conv_pool
    import conv_pkg::*;
#(
    parameter int MAP_W = 8,
    parameter int MAP_H = 8,
    parameter int SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst,
    conv_pool_if.slave  bus
);

    localparam int CW = (MAP_W > 2) ? $clog2(MAP_W) : 1;
    localparam int RW = (MAP_H > 2) ? $clog2(MAP_H) : 1;
    localparam int LD = MAP_W / 2;
    localparam int LW = (LD > 1) ? $clog2(LD) : 1;

    pool_state_t   state_q;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    pix_t          p_q;
    pix_t          line_buf_q [LD];
    pix_t          pool_data_q;
    logic          pool_valid_q;
    logic          frame_done_q;
    logic          busy_q;

    logic          accept;
    logic          last_col;
    logic          last_row;
    logic          odd_col;
    logic          odd_row;
    logic [LW-1:0] lb_idx;
    pix_t          q_pix;
    logic          q_sat;
    pix_t          pair_max;
    pix_t          win_max;

    requant_relu #(
        .SHIFT (SHIFT)
    ) u_requant (
        .data_i (bus.conv_data),
        .pix_o  (q_pix),
        .sat_o  (q_sat)
    );

    // Raster position bookkeeping and the pooling maxima for this sample.
    always_comb begin
        accept   = bus.conv_fin & ~bus.clr;
        last_col = (col_q == CW'(MAP_W - 1));
        last_row = (row_q == RW'(MAP_H - 1));
        odd_col  = col_q[0];
        odd_row  = (state_q == ODD);
        col_d    = last_col ? '0 : col_q + CW'(1);
        row_d    = row_q;
        if (last_col) begin
            row_d = last_row ? '0 : row_q + RW'(1);
        end
        lb_idx   = LW'(col_q >> 1);
        pair_max = pix_max(p_q, q_pix);
        win_max  = pix_max(pair_max, line_buf_q[lb_idx]);
    end

    // Row-parity FSM with position counters and registered pooled outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            pool_data_q  <= '0;
            pool_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else if (bus.clr) begin
            // Abandon the frame; a window already on the outputs has
            // been presented for its one cycle and simply retires here.
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            pool_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            pool_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            if (accept) begin
                col_q  <= col_d;
                row_q  <= row_d;
                busy_q <= !(last_col && last_row);
                case (state_q)
                    IDLE:    state_q <= EVEN;
                    EVEN:    if (last_col) state_q <= ODD;
                    ODD:     if (last_col) state_q <= last_row ? IDLE : EVEN;
                    default: state_q <= IDLE;
                endcase
                if (odd_col && odd_row) begin
                    pool_valid_q <= 1'b1;
                    pool_data_q  <= win_max;
                    frame_done_q <= last_col && last_row;
                end
            end
        end
    end

    // Horizontal pair register and the even-row line buffer of pair maxima.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= '0;
            for (int i = 0; i < LD; i++) begin
                line_buf_q[i] <= '0;
            end
        end else if (accept) begin
            if (!odd_col) begin
                p_q <= q_pix;
            end else if (!odd_row) begin
                line_buf_q[lb_idx] <= pair_max;
            end
        end
    end

`ifdef CONV_POOL_SATCNT_EN
    logic [15:0] sat_count_q;

    // Saturated-sample count, restarted by the first sample of each frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count_q <= '0;
        end else if (bus.clr) begin
            sat_count_q <= '0;
        end else if (accept) begin
            if (state_q == IDLE) begin
                sat_count_q <= {15'd0, q_sat};
            end else if (q_sat && (sat_count_q != 16'hFFFF)) begin
                sat_count_q <= sat_count_q + 16'd1;
            end
        end
    end

    assign bus.sat_count = sat_count_q;
`else
    logic sat_unused;
    assign sat_unused = q_sat;
`endif

    assign bus.pool_data  = pool_data_q;
    assign bus.pool_valid = pool_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_pool.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_pool
//  Purpose  : Self-checking bench for conv_pool. Instance A is 4x2 SHIFT=4,
//             instance B is 8x4 SHIFT=0. A map-level reference model pushes
//             expected windows into per-instance queues; monitors pop them.
//  Options  : CONV_POOL_SATCNT_EN - also checks sat_count.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_pool;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_pool_if ifa ();
    conv_pool_if ifb ();

    conv_pool #(.MAP_W(4), .MAP_H(2), .SHIFT(4)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    conv_pool #(.MAP_W(8), .MAP_H(4), .SHIFT(0)) u_b (.clk(clk), .rst(rst), .bus(ifb));

    typedef struct {
        int data;
        bit fd;
        int cyc;
        int sat;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fd_cnt_b = 0;

    int mw[2] = '{4, 8};
    int mh[2] = '{2, 4};
    int ms[2] = '{4, 0};
    int pos_c[2];
    int pos_r[2];
    int satc[2];
    int map[2][8][8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    // ReLU, shift, clamp to 0..255 with plain integer arithmetic.
    function automatic int rq(input int d, input int s, output bit sat);
        int v;
        sat = 1'b0;
        if (d < 0) return 0;
        v = d / (1 << s);
        if (v > 255) begin
            sat = 1'b1;
            return 255;
        end
        return v;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic model_reset(input int k);
        pos_c[k] = 0;
        pos_r[k] = 0;
    endtask

    task automatic model_accept(input int k, input int d);
        int   q, r, c;
        bit   s;
        exp_t e;
        r = pos_r[k];
        c = pos_c[k];
        q = rq(d, ms[k], s);
        if (r == 0 && c == 0) satc[k] = 0;
        if (s && satc[k] < 65535) satc[k]++;
        map[k][r][c] = q;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            e.data = max4(map[k][r-1][c-1], map[k][r-1][c], map[k][r][c-1], map[k][r][c]);
            e.fd   = (r == mh[k] - 1) && (c == mw[k] - 1);
            e.cyc  = cyc;
            e.sat  = satc[k];
            if (k == 0) exp_a.push_back(e);
            else        exp_b.push_back(e);
        end
        c++;
        if (c == mw[k]) begin
            c = 0;
            r++;
            if (r == mh[k]) r = 0;
        end
        pos_r[k] = r;
        pos_c[k] = c;
    endtask

    // Present one sample (optionally with clr) for one cycle, then idle gap cycles.
    task automatic send(input int k, input int d, input bit clr_too, input int gap);
        int busy_act;
        if (k == 0) begin
            ifa.conv_data = 16'(d); ifa.conv_fin = 1'b1; ifa.clr = clr_too;
        end else begin
            ifb.conv_data = 16'(d); ifb.conv_fin = 1'b1; ifb.clr = clr_too;
        end
        @(posedge clk); #1;
        ifa.conv_fin = 1'b0; ifa.clr = 1'b0;
        ifb.conv_fin = 1'b0; ifb.clr = 1'b0;
        if (clr_too) model_reset(k);
        else         model_accept(k, d);
        busy_act = (k == 0) ? int'(ifa.busy) : int'(ifb.busy);
        chk((k == 0) ? "a_busy" : "b_busy", busy_act, !(pos_c[k] == 0 && pos_r[k] == 0));
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input int k, input int vals[$], input int gap);
        foreach (vals[i]) send(k, vals[i], 1'b0, gap);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_a_data"},  ifa.pool_data,  0);
        chk({tag, "_a_valid"}, ifa.pool_valid, 0);
        chk({tag, "_a_fd"},    ifa.frame_done, 0);
        chk({tag, "_a_busy"},  ifa.busy,       0);
        chk({tag, "_b_data"},  ifb.pool_data,  0);
        chk({tag, "_b_busy"},  ifb.busy,       0);
`ifdef CONV_POOL_SATCNT_EN
        chk({tag, "_a_sat"},   ifa.sat_count,  0);
`endif
    endtask

    // Scoreboard monitor for instance A.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst) begin
            if (ifa.pool_valid) begin
                if (exp_a.size() == 0) begin
                    chk("a_unexpected_valid", 1, 0);
                end else begin
                    e = exp_a.pop_front();
                    chk("a_data",       ifa.pool_data,  e.data);
                    chk("a_frame_done", ifa.frame_done, int'(e.fd));
                    chk("a_latency",    cyc,            e.cyc);
`ifdef CONV_POOL_SATCNT_EN
                    chk("a_sat_count",  ifa.sat_count,  e.sat);
`endif
                end
            end else if (ifa.frame_done) begin
                chk("a_fd_without_valid", 1, 0);
            end
        end
    end

    // Scoreboard monitor for instance B.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst) begin
            if (ifb.frame_done) fd_cnt_b++;
            if (ifb.pool_valid) begin
                if (exp_b.size() == 0) begin
                    chk("b_unexpected_valid", 1, 0);
                end else begin
                    e = exp_b.pop_front();
                    chk("b_data",       ifb.pool_data,  e.data);
                    chk("b_frame_done", ifb.frame_done, int'(e.fd));
                    chk("b_latency",    cyc,            e.cyc);
`ifdef CONV_POOL_SATCNT_EN
                    chk("b_sat_count",  ifb.sat_count,  e.sat);
`endif
                end
            end else if (ifb.frame_done) begin
                chk("b_fd_without_valid", 1, 0);
            end
        end
    end

    initial begin : stim
        int basic[$];
        int negs[$];
        int ones[$];
        int seq[$];
        int d, kind;

        basic = '{160, 320, 480, 640, -160, 80, 800, 32767};
        negs  = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
        ones  = '{16, 16, 16, 16, 16, 16, 16, 16};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                seq.push_back(r * 8 + c);

        rst = 1'b1;
        ifa.clr = 1'b0; ifa.conv_fin = 1'b0; ifa.conv_data = '0;
        ifb.clr = 1'b0; ifb.conv_fin = 1'b0; ifb.conv_data = '0;
        model_reset(0);
        model_reset(1);
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic window, back-to-back samples.
        send_frame(0, basic, 0);
        // Same frame with three idle cycles between samples.
        send_frame(0, basic, 3);
        // All-negative frame.
        send_frame(0, negs, 1);
        // Soft clear with the first sample of row 1, then a fresh frame.
        for (int i = 0; i < 4; i++) send(0, basic[i], 1'b0, 0);
        send(0, basic[4], 1'b1, 0);
        send_frame(0, ones, 0);

        // Asynchronous reset in the middle of row 1.
        for (int i = 0; i < 5; i++) send(0, basic[i], 1'b0, 0);
        rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset(0);
        model_reset(1);
        exp_a.delete();
        exp_b.delete();
        @(posedge clk); #1;
        send_frame(0, basic, 0);

        // Two back-to-back 8x4 frames on instance B.
        fd_cnt_b = 0;
        send_frame(1, seq, 0);
        send_frame(1, seq, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("b_frame_done_count", fd_cnt_b, 2);

        // Randomised frames with mixed magnitudes, gaps and occasional clr.
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 6 * mw[k] * mh[k]; n++) begin
                kind = int'($urandom_range(0, 3));
                case (kind)
                    0:       d = int'($urandom_range(0, 65535)) - 32768;
                    1:       d = int'($urandom_range(0, 4095));
                    2:       d = -int'($urandom_range(1, 32768));
                    default: d = int'($urandom_range(0, 300));
                endcase
                send(k, d, ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) == 0) ? 1 : 0);
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk("a_queue_drained", exp_a.size(), 0);
        chk("b_queue_drained", exp_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
